// File: rtl/serial_add_sub_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
//   sa_state_t : control FSM states (idle, shifting, result-valid pulse)
//   cnt_w()    : bit-counter width for a given operand width
package serial_add_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} sa_state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_sub_if.sv
// Operand/result bundle for serial_add_sub.
//   start, sub, a, b              : request side (driven by master)
//   busy, done, result, cout,
//   overflow                      : status/result side (driven by slave)
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, cout, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, cout, overflow
    );
endinterface

// File: rtl/serial_add_sub_full_adder.sv
// 1-bit full adder cell.
//   a, b, cin : addend bits and carry in
//   s, cout   : sum bit and carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit two's-complement adder/subtractor, LSB first, one bit
// per clock through a single full_adder cell with the carry held in a flop.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : serial_add_sub_if slave (start/sub/a/b in;
//                busy/done/result/cout/overflow out)
// Optional: define SERIAL_ADD_SAT_EN to clamp result to the signed limit on
// overflow (overflow/cout still report the unsaturated condition).
module serial_add_sub
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_add_sub_if.slave bus
);
    localparam int              CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    sa_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Holds the WIDTH-1 low sum bits; the MSB joins them on the final edge.
    logic [WIDTH-2:0] acc_q, acc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             fa_sum;
    logic             fa_co;
    logic [WIDTH-1:0] acc_full;

    full_adder u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (fa_sum),
        .cout (fa_co)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        acc_d    = acc_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        acc_full = {fa_sum, acc_q};

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    // Subtraction as a + ~b + 1: invert B, seed carry with 1.
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d = fa_co;
                acc_d   = acc_full[WIDTH-1:1];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d  = S_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    cout_d   = fa_co;
                    // carry_q is the carry into the MSB on this last step.
                    ovf_d    = carry_q ^ fa_co;
                    result_d = acc_full;
`ifdef SERIAL_ADD_SAT_EN
                    // a_sh_q[0] is operand A's original sign bit here.
                    if (carry_q ^ fa_co) begin
                        result_d = a_sh_q[0] ? {1'b1, {(WIDTH-1){1'b0}}}
                                             : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`else
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub (WIDTH=8): directed cases with literal results,
// then randomized start/operand/reset traffic checked every cycle against a
// reference built from plain integer arithmetic.
module tb_serial_add_sub;
    localparam int WIDTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_en = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    serial_add_sub_if #(.WIDTH(WIDTH)) bus ();

    serial_add_sub #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {result, cout, overflow} from integer arithmetic.
    function automatic logic [WIDTH+1:0] calc(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic s);
        int ux, uy, sx, sy, sr;
        logic [WIDTH-1:0] r;
        logic c, v;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            r  = WIDTH'(ux - uy);
            c  = (ux >= uy);
            sr = sx - sy;
        end else begin
            r  = WIDTH'(ux + uy);
            c  = ((ux + uy) >= (1 << WIDTH));
            sr = sx + sy;
        end
        v = (sr > ((1 << (WIDTH-1)) - 1)) || (sr < -(1 << (WIDTH-1)));
`ifdef SERIAL_ADD_SAT_EN
        if (v) r = x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        return {r, c, v};
    endfunction

    // Reference: an accepted start makes busy last WIDTH cycles, then a
    // one-cycle done with the new result; start while busy is dropped.
    int               m_left = 0;
    logic             m_busy = 1'b0;
    logic             m_done = 1'b0;
    logic [WIDTH-1:0] m_res  = '0;
    logic             m_cout = 1'b0;
    logic             m_ovf  = 1'b0;
    logic [WIDTH+1:0] pend   = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_left <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    {m_res, m_cout, m_ovf} <= pend;
                end
            end else if (bus.start) begin
                pend   <= calc(bus.a, bus.b, bus.sub);
                m_left <= WIDTH;
                m_busy <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",     32'(bus.busy),     32'(m_busy));
            check("done",     32'(bus.done),     32'(m_done));
            check("result",   32'(bus.result),   32'(m_res));
            check("cout",     32'(bus.cout),     32'(m_cout));
            check("overflow", 32'(bus.overflow), 32'(m_ovf));
        end
    end

    // Called at a negedge: presents a request for the next edge, then drops
    // start and scrambles operands (they must not matter after the load).
    task automatic launch(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        bus.sub   = s;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = WIDTH'($urandom);
        bus.b     = WIDTH'($urandom);
        bus.sub   = 1'($urandom);
    endtask

    // Counts edges until done is seen; -1 if it never comes.
    task automatic wait_done(output int n);
        n = 0;
        repeat (40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus.done) return;
        end
        n = -1;
    endtask

    task automatic expect_res(input string name, input logic [WIDTH-1:0] r,
                              input logic c, input logic v);
        check({name, ".result"},   32'(bus.result),   32'(r));
        check({name, ".cout"},     32'(bus.cout),     32'(c));
        check({name, ".overflow"}, 32'(bus.overflow), 32'(v));
    endtask

    task automatic expect_no_done(input string name, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        int n;
        logic [WIDTH-1:0] sat_hi, sat_lo;
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        expect_res("rst", 8'h00, 1'b0, 1'b0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // 1: plain add, latency and busy window
        launch(8'h35, 8'h0A, 1'b0);
        check("t1.busy_after_load", 32'(bus.busy), 32'd1);
        wait_done(n);
        check("t1.latency", 32'(n), 32'd8);
        expect_res("t1", 8'h3F, 1'b0, 1'b0);
        @(negedge clk);
        check("t1.done_pulse_width", 32'(bus.done), 32'd0);

        // 2: subtraction with and without borrow
        launch(8'h10, 8'h01, 1'b1);
        wait_done(n);
        expect_res("t2a", 8'h0F, 1'b1, 1'b0);
        launch(8'h00, 8'h01, 1'b1);
        wait_done(n);
        expect_res("t2b", 8'hFF, 1'b0, 1'b0);

        // 3: signed overflow both directions
`ifdef SERIAL_ADD_SAT_EN
        sat_hi = 8'h7F;
        sat_lo = 8'h80;
`else
        sat_hi = 8'h80;
        sat_lo = 8'h7F;
`endif
        launch(8'h7F, 8'h01, 1'b0);
        wait_done(n);
        expect_res("t3a", sat_hi, 1'b0, 1'b1);
        launch(8'h80, 8'h01, 1'b1);
        wait_done(n);
        expect_res("t3b", sat_lo, 1'b1, 1'b1);

        // 4: unsigned wrap, then back-to-back start in the done cycle
        launch(8'hFF, 8'h01, 1'b0);
        wait_done(n);
        expect_res("t4a", 8'h00, 1'b1, 1'b0);
        launch(8'h02, 8'h03, 1'b0);
        check("t4.no_bubble_busy", 32'(bus.busy), 32'd1);
        wait_done(n);
        check("t4.latency", 32'(n), 32'd8);
        expect_res("t4b", 8'h05, 1'b0, 1'b0);

        // 5: start mid-run is ignored
        @(negedge clk);
        launch(8'h21, 8'h13, 1'b0);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h55;
        bus.b     = 8'h66;
        bus.sub   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n);
        check("t5.latency", 32'(n), 32'd5);
        expect_res("t5", 8'h34, 1'b0, 1'b0);
        expect_no_done("t5.single_done", 12);

        // 6: reset mid-run aborts, then a clean op
        launch(8'h44, 8'h22, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t6.busy", 32'(bus.busy), 32'd0);
        expect_res("t6.cleared", 8'h00, 1'b0, 1'b0);
        expect_no_done("t6.no_done", 12);
        launch(8'h44, 8'h22, 1'b1);
        wait_done(n);
        check("t6.latency", 32'(n), 32'd8);
        expect_res("t6", 8'h22, 1'b1, 1'b0);

        // Random traffic: frequent starts, occasional resets
        repeat (800) begin
            @(negedge clk);
            rst_n     = ($urandom_range(0, 149) != 0);
            bus.start = ($urandom_range(0, 2) == 0);
            bus.a     = WIDTH'($urandom);
            bus.b     = WIDTH'($urandom);
            bus.sub   = 1'($urandom);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        bus.start = 1'b0;
        repeat (12) @(negedge clk);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
